// File: rtl/imem_loader_if.sv
// Byte-stream intake and instruction-memory write port of the image loader.
`ifndef THREAD_WIDTH
`define THREAD_WIDTH 3
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

interface imem_loader_if;
    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      wr_en;
    logic [`THREAD_WIDTH-1:0]  wr_thread;
    logic [`XLEN-1:0]          wr_addr;
    logic [`INSTR_WIDTH-1:0]   wr_data;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_thread, wr_addr, wr_data
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_thread, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Parses framed instruction images from a byte stream and writes them into
// per-thread instruction memory, holding the core off until a frame checks out.
//
// state  | meaning
// IDLE   | waiting for frame header byte (magic + thread id)
// CNT_LO | receiving low byte of word count
// CNT_HI | receiving high byte of word count, range check
// DATA   | assembling little-endian words, one write per 4 bytes
// CSUM   | comparing checksum byte against running XOR
// DONE   | one-cycle success pulse, core released
// ERR    | one-cycle reject pulse, core_hold left as-is
`ifndef THREAD_WIDTH
`define THREAD_WIDTH 3
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module imem_loader #(
    parameter int IMEM_WORDS = 256,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_if.slave      bus,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int               IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(IMEM_WORDS);
    localparam logic [4:0]       MAGIC = 5'b10100;

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t             state, state_nxt;
    logic               rx_ready;
    logic               accept;
    logic [2:0]         tid;
    logic [7:0]         cnt_lo;
    logic [CNT_W-1:0]   cnt_full;
    logic               count_ok;
    logic [CNT_W-1:0]   word_last;
    logic [IDX_W-1:0]   word_idx;
    logic               last_word;
    logic [1:0]         lane;
    logic [23:0]        word_acc;
    logic [7:0]         csum;

    assign accept    = bus.rx_valid && rx_ready;
    assign cnt_full  = {bus.rx_data, cnt_lo};
    assign count_ok  = (cnt_full != '0) && (cnt_full <= MAX_N);
    assign last_word = (CNT_W'(word_idx) == word_last);
    assign bus.rx_ready = rx_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE:   if (accept) state_nxt = (bus.rx_data[7:3] == MAGIC) ? S_CNT_LO : S_ERR;
            S_CNT_LO: if (accept) state_nxt = S_CNT_HI;
            S_CNT_HI: if (accept) state_nxt = count_ok ? S_DATA : S_ERR;
            S_DATA:   if (accept && (lane == 2'd3) && last_word) state_nxt = S_CSUM;
            S_CSUM:   if (accept) state_nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
            S_DONE: begin
                rx_ready  = 1'b0;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                rx_ready  = 1'b0;
                err       = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tid           <= '0;
            cnt_lo        <= '0;
            word_last     <= '0;
            word_idx      <= '0;
            lane          <= '0;
            word_acc      <= '0;
            csum          <= '0;
            core_hold     <= 1'b0;
            err_code      <= 2'b00;
            bus.wr_en     <= 1'b0;
            bus.wr_thread <= '0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (bus.rx_data[7:3] == MAGIC) begin
                            tid       <= bus.rx_data[2:0];
                            core_hold <= 1'b1;
                            csum      <= '0;
                        end else begin
                            err_code  <= 2'b01;
                        end
                    end
                    S_CNT_LO: cnt_lo <= bus.rx_data;
                    S_CNT_HI: begin
                        word_last <= cnt_full - CNT_W'(1);
                        word_idx  <= '0;
                        lane      <= '0;
                        if (!count_ok) err_code <= 2'b10;
                    end
                    S_DATA: begin
                        csum <= csum ^ bus.rx_data;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            // Write only once the whole word is in hand.
                            bus.wr_en     <= 1'b1;
                            bus.wr_thread <= `THREAD_WIDTH'(tid);
                            bus.wr_addr   <= `XLEN'({word_idx, 2'b00});
                            bus.wr_data   <= `INSTR_WIDTH'({bus.rx_data, word_acc});
                            if (!last_word) word_idx <= word_idx + IDX_W'(1);
                        end else begin
                            word_acc[lane*8 +: 8] <= bus.rx_data;
                        end
                    end
                    S_CSUM: begin
                        if (bus.rx_data == csum) core_hold <= 1'b0;
                        else                     err_code  <= 2'b11;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and done/err events are
// queued as frames are driven and matched when the loader produces them.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       core_hold, done, err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    imem_loader_if bus();

    imem_loader #(.IMEM_WORDS(256), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .core_hold (core_hold),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  thr;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic       is_err;
        logic [1:0] code;
        logic       hold;
    } ev_t;

    wr_t         wq[$];
    ev_t         eq[$];
    logic [31:0] img[256];
    bit          gaps = 1'b0;

    always @(negedge clk) begin
        wr_t w;
        ev_t e;
        if (!rst) begin
            if (bus.wr_en) begin
                if (wq.size() == 0) chk("wr_unexpected", bus.wr_en, 1'b0);
                else begin
                    w = wq.pop_front();
                    chk("wr_thread", bus.wr_thread, w.thr);
                    chk("wr_addr", bus.wr_addr, w.addr);
                    chk("wr_data", bus.wr_data, w.data);
                end
            end
            if (done || err) begin
                if (eq.size() == 0) chk("ev_unexpected", {done, err}, 2'b00);
                else begin
                    e = eq.pop_front();
                    chk("ev_kind", {done, err}, e.is_err ? 2'b01 : 2'b10);
                    if (e.is_err) chk("err_code", err_code, e.code);
                    chk("ev_hold", core_hold, e.hold);
                    chk("ev_ready", bus.rx_ready, 1'b0);
                end
            end
        end
    end

    task automatic push_ev(input logic is_err, input logic [1:0] code, input logic hold);
        ev_t e;
        e.is_err = is_err;
        e.code   = code;
        e.hold   = hold;
        eq.push_back(e);
    endtask

    // Enter and leave at a negedge; returns after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int budget = 0;
        if (gaps) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.rx_ready) chk("ready_timeout", bus.rx_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [2:0] tid, input int n, input bit bad_csum);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        wr_t        w;
        send_byte({5'b10100, tid});
        chk("hold_start", core_hold, 1'b1);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                b = img[i][8*j +: 8];
                x = x ^ b;
                if (j == 3) begin
                    w.thr  = tid;
                    w.addr = 32'(i) << 2;
                    w.data = img[i];
                    wq.push_back(w);
                end
                send_byte(b);
            end
        end
        if (bad_csum) push_ev(1'b1, 2'b11, 1'b1);
        else          push_ev(1'b0, 2'b00, 1'b0);
        send_byte(bad_csum ? ~x : x);
        bus.rx_valid = 1'b0;
    endtask

    task automatic settle(input string tag);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_wq_empty"}, wq.size(), 0);
        chk({tag, "_eq_empty"}, eq.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, bus.rx_ready, 1'b1);
        chk({tag, "_wr_en"}, bus.wr_en, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_err_code"}, err_code, 2'b00);
        chk({tag, "_hold"}, core_hold, 1'b0);
        chk({tag, "_wr_thread"}, bus.wr_thread, 3'd0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
        chk({tag, "_wr_data"}, bus.wr_data, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst0");

        // Two-word frame into thread 3
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        send_frame(3'd3, 2, 1'b0);
        settle("frame_a");
        chk("a_hold_after", core_hold, 1'b0);
        chk("a_addr_hold", bus.wr_addr, 32'h4);
        chk("a_data_hold", bus.wr_data, 32'h0010_0093);

        // Bad magic: no frame started, hold stays low
        push_ev(1'b1, 2'b01, 1'b0);
        send_byte(8'h55);
        settle("magic");
        chk("magic_hold", core_hold, 1'b0);

        // Word count 0 and 257 rejected after header
        push_ev(1'b1, 2'b10, 1'b1);
        send_byte(8'hA0); send_byte(8'h00); send_byte(8'h00);
        settle("cnt0");
        push_ev(1'b1, 2'b10, 1'b1);
        send_byte(8'hA0); send_byte(8'h01); send_byte(8'h01);
        settle("cnt257");
        chk("cnt_hold", core_hold, 1'b1);

        // Wrong checksum: word still written, then recovery with a good frame
        img[0] = $urandom;
        send_frame(3'd5, 1, 1'b1);
        settle("bad_csum");
        chk("csum_hold", core_hold, 1'b1);
        img[0] = $urandom;
        send_frame(3'd1, 1, 1'b0);
        settle("recover");
        chk("recover_hold", core_hold, 1'b0);

        // Same 4-word image with random rx_valid gaps and then gap-free
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        gaps = 1'b1;
        send_frame(3'd6, 4, 1'b0);
        gaps = 1'b0;
        settle("gappy");
        send_frame(3'd6, 4, 1'b0);
        settle("nogap");

        // Full-size image followed immediately by a 1-word frame
        for (int i = 0; i < 256; i++) img[i] = $urandom;
        send_frame(3'd7, 256, 1'b0);
        send_frame(3'd2, 1, 1'b0);
        settle("max_b2b");

        // Reset partway through the first word
        send_byte(8'hA4); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst_mid");
        settle("rst_mid");

        img[0] = $urandom;
        send_frame(3'd4, 1, 1'b0);
        settle("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
